// File: rtl/uart_mmio_bridge.sv
// uart_mmio_bridge
//   Device-side UART controller between a 32-bit register bus and the
//   simulation UART model's byte channels. TX/RX FIFOs decouple bus timing
//   from the model; a registered level interrupt reports RX data / TX drained.
//
// Ports
//   clock, reset_n          : clock, asynchronous active-low reset
//   reg_req_*               : register request (valid/ready, write, addr, wdata)
//   reg_resp_valid/rdata    : one-cycle response, cycle after acceptance
//   serial_out_*            : TX byte stream to the model (valid/ready/bits)
//   serial_in_*             : RX byte stream from the model (valid/ready/bits)
//   irq                     : level interrupt
//
// Register map (addr[3:2]): 0 TXDATA, 1 RXDATA, 2 STATUS, 3 IE
module uart_mmio_bridge #(
    parameter int unsigned FIFO_DEPTH = 8,
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        reg_req_valid,
    output logic        reg_req_ready,
    input  logic        reg_req_write,
    input  logic [3:0]  reg_req_addr,
    input  logic [31:0] reg_req_wdata,
    output logic        reg_resp_valid,
    output logic [31:0] reg_resp_rdata,
    output logic        serial_out_valid,
    input  logic        serial_out_ready,
    output logic [7:0]  serial_out_bits,
    input  logic        serial_in_valid,
    output logic        serial_in_ready,
    input  logic [7:0]  serial_in_bits,
    output logic        irq
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        REG_TXDATA = 2'd0,
        REG_RXDATA = 2'd1,
        REG_STATUS = 2'd2,
        REG_IE     = 2'd3
    } reg_sel_e;

    // Control state
    logic        ready_q;
    logic        resp_valid_q;
    logic [31:0] resp_rdata_q;
    logic        irq_q;
    logic        tx_ovf_q;
    logic        rx_ie_q;
    logic        tx_ie_q;

    // TX FIFO
    logic [7:0]       tx_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] tx_wptr, tx_rptr;
    logic [CNT_W-1:0] tx_count;

    // RX FIFO
    logic [7:0]       rx_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rx_wptr, rx_rptr;
    logic [CNT_W-1:0] rx_count;

    logic     accept;
    reg_sel_e sel;
    logic     tx_full, tx_empty, rx_full, rx_empty;
    logic     tx_wr, tx_push, tx_pop, rx_push, rx_pop;
    logic     status_wr, ie_wr;
    logic [31:0] status_word;
    logic [31:0] rdata_next;
    logic     unused_bits;

    assign unused_bits = ^{reg_req_addr[1:0], reg_req_wdata[31:8]};

    assign accept   = reg_req_valid & ready_q;
    assign sel      = reg_sel_e'(reg_req_addr[3:2]);

    // Full/empty always reflect start-of-cycle occupancy.
    assign tx_full  = (tx_count == CNT_W'(FIFO_DEPTH));
    assign tx_empty = (tx_count == '0);
    assign rx_full  = (rx_count == CNT_W'(FIFO_DEPTH));
    assign rx_empty = (rx_count == '0);

    assign tx_wr     = accept & reg_req_write & (sel == REG_TXDATA);
    assign tx_push   = tx_wr & ~tx_full;
    assign tx_pop    = ~tx_empty & serial_out_ready;
    assign rx_push   = serial_in_valid & serial_in_ready;
    assign rx_pop    = accept & ~reg_req_write & (sel == REG_RXDATA) & ~rx_empty;
    assign status_wr = accept & reg_req_write & (sel == REG_STATUS);
    assign ie_wr     = accept & reg_req_write & (sel == REG_IE);

    // Outputs come straight from registered state.
    assign reg_req_ready    = ready_q;
    assign reg_resp_valid   = resp_valid_q;
    assign reg_resp_rdata   = resp_rdata_q;
    assign serial_out_valid = ~tx_empty;
    assign serial_out_bits  = tx_mem[tx_rptr];
    assign serial_in_ready  = ready_q & ~rx_full;
    assign irq              = irq_q;

    always_comb begin
        status_word        = '0;
        status_word[0]     = tx_full;
        status_word[1]     = tx_empty;
        status_word[2]     = rx_empty;
        status_word[3]     = rx_full;
        status_word[4]     = tx_ovf_q;
        status_word[11:8]  = 4'(rx_count);
        status_word[19:16] = 4'(tx_count);
    end

    always_comb begin
        rdata_next = '0;
        if (accept && !reg_req_write) begin
            unique case (sel)
                REG_TXDATA: rdata_next = '0;
                REG_RXDATA: rdata_next = rx_empty ? 32'h8000_0000 : {24'b0, rx_mem[rx_rptr]};
                REG_STATUS: rdata_next = status_word;
                REG_IE:     rdata_next = {30'b0, tx_ie_q, rx_ie_q};
                default:    rdata_next = '0;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ready_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            irq_q        <= 1'b0;
            tx_ovf_q     <= 1'b0;
            rx_ie_q      <= 1'b0;
            tx_ie_q      <= 1'b0;
        end else begin
            ready_q      <= 1'b1;
            resp_valid_q <= accept;
            resp_rdata_q <= rdata_next;
            irq_q        <= (rx_ie_q & ~rx_empty) | (tx_ie_q & tx_empty);
            if (tx_wr && tx_full) begin
                tx_ovf_q <= 1'b1;
            end else if (status_wr && reg_req_wdata[4]) begin
                tx_ovf_q <= 1'b0;
            end
            if (ie_wr) begin
                rx_ie_q <= reg_req_wdata[0];
                tx_ie_q <= reg_req_wdata[1];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                tx_mem[i] <= '0;
            end
            tx_wptr  <= '0;
            tx_rptr  <= '0;
            tx_count <= '0;
        end else begin
            if (tx_push) begin
                tx_mem[tx_wptr] <= reg_req_wdata[7:0];
                tx_wptr         <= tx_wptr + PTR_W'(1);
            end
            if (tx_pop) begin
                tx_rptr <= tx_rptr + PTR_W'(1);
            end
            tx_count <= tx_count + CNT_W'(tx_push) - CNT_W'(tx_pop);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                rx_mem[i] <= '0;
            end
            rx_wptr  <= '0;
            rx_rptr  <= '0;
            rx_count <= '0;
        end else begin
            if (rx_push) begin
                rx_mem[rx_wptr] <= serial_in_bits;
                rx_wptr         <= rx_wptr + PTR_W'(1);
            end
            if (rx_pop) begin
                rx_rptr <= rx_rptr + PTR_W'(1);
            end
            rx_count <= rx_count + CNT_W'(rx_push) - CNT_W'(rx_pop);
        end
    end

endmodule

// File: doc/uart_mmio_bridge.md
# uart_mmio_bridge

Device-side UART controller that sits directly in front of the simulation UART model. It converts 32-bit register reads and writes from the core's peripheral bus into byte streams on the model's `serial_out` and `serial_in` valid/ready channels. A TX FIFO and an RX FIFO decouple bus timing from the model's per-cycle tick, and a level interrupt reports RX data available and TX drained.

## Interface
- `FIFO_DEPTH`, 8: entries per FIFO; power of two, ≥2.
- `CNT_W`, $clog2(FIFO_DEPTH)+1: occupancy counter width (derived; do not override).

- `clock`  in  1  sole clock; all state updates on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `reg_req_valid`  in  1  bus request present.
- `reg_req_ready`  out  1  request accepted.
- `reg_req_write`  in  1  1 = write, 0 = read.
- `reg_req_addr`  in  4  byte offset; bits [3:2] select the register.
- `reg_req_wdata`  in  32  write data.
- `reg_resp_valid`  out  1  one-cycle response pulse.
- `reg_resp_rdata`  out  32  read data; 0 for writes.
- `serial_out_valid`  out  1  TX byte available to the model.
- `serial_out_ready`  in  1  model accepts the TX byte.
- `serial_out_bits`  out  8  TX byte.
- `serial_in_valid`  in  1  model offers an RX byte.
- `serial_in_ready`  out  1  bridge can accept an RX byte.
- `serial_in_bits`  in  8  RX byte.
- `irq`  out  1  level interrupt.

## Operation
- Register map:
  - 0x0 TXDATA:
    - Write pushes `wdata[7:0]` into the TX FIFO.
    - A write while full drops the byte and sets sticky `tx_ovf`.
    - Reads return 0.
  - 0x4 RXDATA:
    - Read when not empty returns `{1'b0, 23'b0, byte}` and pops the RX FIFO.
    - Read when empty returns `32'h8000_0000` and does not pop.
    - Writes are ignored.
  - 0x8 STATUS, read fields:
    - [0] `tx_full`, [1] `tx_empty`, [2] `rx_empty`, [3] `rx_full`, [4] `tx_ovf`.
    - [11:8] `rx_count`, [19:16] `tx_count`.
    - Counts are zero-extended or truncated to 4 bits.
    - Write: `wdata[4]`=1 clears `tx_ovf` (write-1-to-clear); other bits are ignored.
  - 0xC IE:
    - R/W [0] `rx_ie`, [1] `tx_ie`; upper bits read 0.
- Interrupt: `irq` = (`rx_ie` & !`rx_empty`) | (`tx_ie` & `tx_empty`), registered.
- TX channel:
  - `serial_out_valid` = !`tx_empty`; `serial_out_bits` = TX head entry. Both are driven from registers only.
  - The FIFO pops when `serial_out_valid` & `serial_out_ready`.
- RX channel:
  - `serial_in_ready` = !`rx_full` (registered state).
  - The FIFO pushes `serial_in_bits` when `serial_in_valid` & `serial_in_ready`.
- FIFOs:
  - Circular buffers with wrapping read/write pointers and CNT_W-bit occupancy counters.
  - A simultaneous push and pop in the same cycle leaves the count unchanged.
- All full and empty decisions use start-of-cycle state:
  - A TXDATA write to a full FIFO is dropped even if the model pops in the same cycle.
  - An RXDATA read of an empty FIFO returns empty even if the model pushes in the same cycle.
- Unmapped offsets do not exist (4 registers fill the 16-byte space). Bits [1:0] of `reg_req_addr` are ignored.

## Timing
- Reset values:
  - `reg_req_ready`=0 during reset, then constant 1.
  - `reg_resp_valid`=0, `reg_resp_rdata`=0.
  - `serial_out_valid`=0, `serial_out_bits`=0.
  - `serial_in_ready`=0 during reset, then 1.
  - `irq`=0.
  - Both FIFOs empty, `tx_ovf`=0, IE=0.
- Requests complete at most one per cycle. The accepting cycle is N; `reg_resp_valid`=1 and `rdata` are presented in cycle N+1 for exactly one cycle.
- RXDATA pop and all register writes take effect at the edge ending cycle N.
- TX latency: a write accepted in cycle N to an empty TX FIFO gives `serial_out_valid`=1 in N+1.
- RX latency: a byte handshaken in cycle N is readable by a request in cycle N+1.
- `irq` lags the causing state change by one cycle.
- Reset asserted mid-transfer clears everything asynchronously; in-flight bytes are discarded and no response is issued for a request pending at reset.

## Test plan
- Reset → all outputs 0. After release: `reg_req_ready`=1, `serial_in_ready`=1, STATUS read = `32'h0000_0006`.
- Write 0x41, 0x42 to TXDATA with `serial_out_ready`=1 → `serial_out_bits` 0x41 then 0x42 on consecutive cycles, then `serial_out_valid`=0 and STATUS[1]=1.
- Hold `serial_out_ready`=0 and write 9 bytes at depth 8 → ninth byte dropped, STATUS[0]=1, STATUS[4]=1. Write STATUS with 0x10 → bit4 clears. Release ready → exactly 8 bytes are drained, in order.
- Model pushes 8 bytes, then offers more → `serial_in_ready`=0 when full. RXDATA reads return the bytes in order; a ninth read returns `32'h8000_0000`.
- Set IE=0x1, model pushes 0x55 → `irq`=1 two cycles after the handshake. Read RXDATA → `irq`=0 one cycle after the pop.
- With TX full, write TXDATA in the same cycle the model pops → byte dropped and `tx_ovf` set. Assert `reset_n`=0 mid-stream → outputs 0 immediately, FIFOs empty after release.
